// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and iteration count.
package muldiv_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } md_state_t;

  // Signed variants are MULT and DIV; everything else treats operands as raw bits.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring
// shift-subtract divide step, selected by div_mode.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         div_mode,
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] low_in,
  input  logic [W-1:0] operand,
  output logic [W:0]   rem_out,
  output logic [W-1:0] low_out
);

  logic [W:0]   sum;
  logic [W:0]   rem_shift;
  logic [W+1:0] trial;

  always_comb begin
    sum       = rem_in + (low_in[0] ? {1'b0, operand} : '0);
    rem_shift = {rem_in[W-1:0], low_in[W-1]};
    trial     = {1'b0, rem_shift} - {2'b0, operand};
    rem_out   = '0;
    low_out   = '0;
    if (div_mode) begin
      // A clear borrow bit means the trial subtraction stays non-negative.
      if (!trial[W+1]) begin
        rem_out = trial[W:0];
        low_out = {low_in[W-2:0], 1'b1};
      end else begin
        rem_out = rem_shift;
        low_out = {low_in[W-2:0], 1'b0};
      end
    end else begin
      rem_out = {1'b0, sum[W:1]};
      low_out = {sum[0], low_in[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers;
// 32 iterations per MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [2:0]          op,
  input  logic [bit_size-1:0] rs_data,
  input  logic [bit_size-1:0] rt_data,
  output logic [bit_size-1:0] hi,
  output logic [bit_size-1:0] lo,
  output logic                busy,
  output logic                stall
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITER - 1);

  md_state_t           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [bit_size:0]   rem_q, rem_d;
  logic [bit_size-1:0] low_q, low_d;
  logic [bit_size-1:0] opnd_q, opnd_d;
  logic                div_q, div_d;
  logic                neg_main_q, neg_main_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [bit_size-1:0] rs_orig_q, rs_orig_d;
  logic [bit_size-1:0] hi_q, hi_d;
  logic [bit_size-1:0] lo_q, lo_d;

  logic [bit_size:0]     step_rem;
  logic [bit_size-1:0]   step_low;
  logic                  op_signed;
  logic [bit_size-1:0]   rs_abs, rt_abs;
  logic [2*bit_size-1:0] prod_raw, prod_fix;
  logic [bit_size-1:0]   quo_fix, rem_fix;

  muldiv_step #(.W(bit_size)) u_step (
    .div_mode (div_q),
    .rem_in   (rem_q),
    .low_in   (low_q),
    .operand  (opnd_q),
    .rem_out  (step_rem),
    .low_out  (step_low)
  );

  always_comb begin
    op_signed = md_is_signed(op);
    rs_abs    = (op_signed && rs_data[bit_size-1]) ? -rs_data : rs_data;
    rt_abs    = (op_signed && rt_data[bit_size-1]) ? -rt_data : rt_data;
    prod_raw  = {step_rem[bit_size-1:0], step_low};
    prod_fix  = neg_main_q ? -prod_raw : prod_raw;
    quo_fix   = neg_main_q ? -step_low : step_low;
    rem_fix   = neg_rem_q ? -step_rem[bit_size-1:0] : step_rem[bit_size-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    low_d      = low_q;
    opnd_d     = opnd_q;
    div_d      = div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    rs_orig_d  = rs_orig_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d    = CALC;
              cnt_d      = '0;
              div_d      = op[1];
              rem_d      = '0;
              low_d      = op[1] ? rs_abs : rt_abs;
              opnd_d     = op[1] ? rt_abs : rs_abs;
              neg_main_d = op_signed & (rs_data[bit_size-1] ^ rt_data[bit_size-1]);
              neg_rem_d  = op_signed & rs_data[bit_size-1];
              dz_d       = op[1] & (rt_data == '0);
              rs_orig_d  = rs_data;
            end
            MD_MTHI: hi_d = rs_data;
            MD_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      CALC: begin
        rem_d = step_rem;
        low_d = step_low;
        cnt_d = cnt_q + 1'b1;
        // The last iteration's result goes straight to HI/LO with sign fix-up.
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!div_q) begin
            hi_d = prod_fix[2*bit_size-1:bit_size];
            lo_d = prod_fix[bit_size-1:0];
          end else if (dz_q) begin
            hi_d = rs_orig_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      low_q      <= '0;
      opnd_q     <= '0;
      div_q      <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      rs_orig_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      low_q      <= low_d;
      opnd_q     <= opnd_d;
      div_q      <= div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      rs_orig_q  <= rs_orig_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == CALC);
  assign stall = op_valid & busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO come from a behavioural
// arithmetic model pushed at issue time and popped when busy drops.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          pass_cnt;
  int          total_cnt;

  muldiv_unit #(.bit_size(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    else
      pass_cnt++;
  endtask

  // Independent arithmetic reference built on native SV operators.
  task automatic modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sbv;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(sp);
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_hi = 32'd0;
          m_lo = 32'h8000_0000;
        end else begin
          sa   = $signed(a);
          sbv  = $signed(b);
          m_lo = 32'(sa / sbv);
          m_hi = 32'(sa % sbv);
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
    sb.push_back('{hi: m_hi, lo: m_lo});
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input bit inject);
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    exp_t        e;
    int          cycles;
    bit          done;
    prev_hi = m_hi;
    prev_lo = m_lo;
    modelOp(o, a, b);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    if (o <= 3'd3) begin
      checkOutput("busy_on", {31'b0, busy}, 32'd1);
      cycles = 1;
      done   = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
        if (inject && cycles == 10) begin
          op_valid = 1'b1;
          op       = MD_MULT;
          rs_data  = 32'd2;
          rt_data  = 32'd2;
          #1;
          checkOutput("stall_busy", {31'b0, stall}, 32'd1);
        end
        if (inject && cycles == 11) begin
          op      = MD_MTHI;
          rs_data = 32'h0000_1234;
        end
        if (inject && cycles == 12) op_valid = 1'b0;
        if (cycles == 16) begin
          checkOutput("hold_hi", hi, prev_hi);
          checkOutput("hold_lo", lo, prev_lo);
        end
        @(posedge clk);
        #1;
        if (!busy) done = 1'b1;
        else cycles++;
      end
      if (!done) checkOutput("busy_timeout", 32'd0, 32'd1);
      checkOutput("busy_cycles", cycles, 32'd32);
    end else begin
      checkOutput("busy_off", {31'b0, busy}, 32'd0);
    end
    e = sb.pop_front();
    checkOutput("hi", hi, e.hi);
    checkOutput("lo", lo, e.lo);
  endtask

  initial begin
    exp_t e;
    pass_cnt  = 0;
    total_cnt = 0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op        = 3'd0;
    rs_data   = 32'd0;
    rt_data   = 32'd0;
    #12;
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MD_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0);
    applyStimulus(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
    applyStimulus(MD_DIVU,  32'd7,         32'd2,         1'b0);
    applyStimulus(MD_DIVU,  32'd5,         32'd0,         1'b0);
    applyStimulus(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MD_DIV,   32'hFFFF_FFF9, 32'd0,         1'b0);
    applyStimulus(MD_DIV,   32'd100,       32'hFFFF_FFF9, 1'b0);
    applyStimulus(MD_MULT,  32'd6,         32'd7,         1'b1);
    applyStimulus(MD_MTLO,  32'h0000_ABCD, 32'd0,         1'b0);
    applyStimulus(MD_MTHI,  32'h5555_AAAA, 32'd0,         1'b0);
    applyStimulus(3'd6,     32'hDEAD_BEEF, 32'd1,         1'b0);

    for (int i = 0; i < 4; i++)
      applyStimulus(3'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 28), 1'b0);

    // Asynchronous reset in the middle of a divide.
    modelOp(MD_DIVU, 32'd1000, 32'd7);
    @(negedge clk);
    op_valid = 1'b1;
    op       = MD_DIVU;
    rs_data  = 32'd1000;
    rt_data  = 32'd7;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    e = sb.pop_front();
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    #3;
    rst = 1'b0;

    applyStimulus(MD_MULTU, 32'd3, 32'd5, 1'b0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
